// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_pkg
// Description : OBI request/response channel types shared by initiators and
//               responders on the crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage : obi_pkg
`default_nettype wire

// File: rtl/obi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_sram_responder_pkg
// Description : Address-window helpers and defaults for the OBI SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_sram_responder_pkg;

  // Read data returned for accesses that miss the memory window.
  localparam logic [31:0] c_ERR_RDATA = 32'hBADC_ACCE;

  // True when addr lies in [base, base + 4*num_words).
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned num_words);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset < (num_words << 2));
  endfunction

  // Word offset from the window base; the caller truncates to its index width.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage : obi_sram_responder_pkg
`default_nettype wire

// File: rtl/obi_sram_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : obi_sram_responder_mem
// Description : Flop-based 32-bit word memory, one read/write port, byte-lane
//               write enables and a registered (synchronous) read.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_sram_responder_mem #(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] r_mem [NUM_WORDS];
  logic [31:0] r_rdata;

  // Storage array: contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) r_mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register captures the word as it was before any same-cycle write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= 32'h0;
    end else if (en_i) begin
      r_rdata <= r_mem[idx_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule : obi_sram_responder_mem
`default_nettype wire

// File: rtl/obi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_sram_responder
// Description : OBI responder terminating crossbar transactions into a small
//               scratch memory, with programmable grant wait, out-of-window
//               error pulse and a granted-transaction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_sram_responder
  import obi_pkg::*;
  import obi_sram_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter int unsigned GNT_DELAY = 0,
  parameter logic [31:0] ERR_RDATA = c_ERR_RDATA
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_resp_t   obi_resp_o,
  output logic        err_o,
  output logic [31:0] access_cnt_o
);

  localparam int unsigned c_IDX_W     = $clog2(NUM_WORDS);
  localparam logic [3:0]  c_WAIT_LOAD = 4'(GNT_DELAY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [3:0]         r_wait_cnt;
  logic [3:0]         w_wait_cnt_d;
  logic               w_gnt;
  logic               w_inwin;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_mem_rdata;
  logic               r_rvalid;
  logic               r_we;
  logic               r_inwin;
  logic [31:0]        r_access_cnt;

  assign w_inwin = in_window(obi_req_i.addr, BASE_ADDR, NUM_WORDS);
  assign w_idx   = c_IDX_W'(word_offset(obi_req_i.addr, BASE_ADDR));

  // Grant FSM register and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'h0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
    end
  end

  // Next state and grant: immediate grant when no wait is configured,
  // otherwise count down while req is held and abandon if req drops.
  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    w_gnt        = 1'b0;
    case (r_state)
      IDLE: begin
        if (obi_req_i.req) begin
          if (GNT_DELAY == 0) begin
            w_gnt = 1'b1;
          end else begin
            w_state_d    = WAIT;
            w_wait_cnt_d = c_WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!obi_req_i.req) begin
          w_state_d = IDLE;
        end else if (r_wait_cnt == 4'h0) begin
          w_gnt     = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_wait_cnt_d = r_wait_cnt - 4'h1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Response tracking: rvalid follows each grant by one cycle; the access
  // kind and window flag are kept so rdata holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid     <= 1'b0;
      r_we         <= 1'b0;
      r_inwin      <= 1'b1;
      r_access_cnt <= 32'h0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_we         <= obi_req_i.we;
        r_inwin      <= w_inwin;
        r_access_cnt <= r_access_cnt + 32'h1;
      end
    end
  end

  // Out-of-window accesses never touch the memory, so writes are dropped.
  obi_sram_responder_mem #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (c_IDX_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (w_gnt & w_inwin),
    .we_i    (obi_req_i.we),
    .be_i    (obi_req_i.be),
    .idx_i   (w_idx),
    .wdata_i (obi_req_i.wdata),
    .rdata_o (w_mem_rdata)
  );

  assign obi_resp_o.gnt    = w_gnt;
  assign obi_resp_o.rvalid = r_rvalid;
  assign obi_resp_o.rdata  = r_we    ? 32'h0 :
                             r_inwin ? w_mem_rdata : ERR_RDATA;
  assign err_o             = r_rvalid & ~r_inwin;
  assign access_cnt_o      = r_access_cnt;

endmodule : obi_sram_responder
`default_nettype wire

// File: tb/tb_obi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_sram_responder
// Description : Self-checking bench; three responders with grant waits of
//               0, 3 and 5 cycles against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_sram_responder;
  import obi_pkg::*;

  localparam int unsigned NW   = 16;
  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam logic [31:0] ERR  = 32'hBADC_ACCE;

  logic        clk = 1'b0;
  logic        rst_n [3];
  obi_req_t    req   [3];
  obi_resp_t   resp  [3];
  logic        err   [3];
  logic [31:0] cnt   [3];

  // Reference model state.
  logic [31:0] mdl  [3][NW];
  int unsigned mcnt [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      obi_sram_responder #(
        .NUM_WORDS (NW),
        .BASE_ADDR (BASE),
        .GNT_DELAY ((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
        .ERR_RDATA (ERR)
      ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n[g]),
        .obi_req_i    (req[g]),
        .obi_resp_o   (resp[g]),
        .err_o        (err[g]),
        .access_cnt_o (cnt[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Model: one access; returns expected rdata and error flag, commits writes.
  task automatic model_access(input int k, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rdata, output logic exp_err);
    longint a;
    int     idx;
    logic   inwin;
    a     = longint'(addr);
    inwin = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * NW);
    idx   = int'((a - longint'(BASE)) / 4);
    exp_err = !inwin;
    if (we)         exp_rdata = 32'h0;
    else if (inwin) exp_rdata = mdl[k][idx];
    else            exp_rdata = ERR;
    if (we && inwin)
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
    mcnt[k]++;
  endtask

  // One complete transaction: grant latency, then the response beat.
  task automatic access(input int k, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, output logic [31:0] got);
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    @(negedge clk);
    req[k] = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
    lat = 0;
    #1;
    while (!resp[k].gnt && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check("gnt_latency", 32'(lat), 32'(exp_lat));
    model_access(k, we, be, addr, wdata, exp_rdata, exp_err);
    @(negedge clk);
    req[k].req = 1'b0;
    #1;
    got = resp[k].rdata;
    check("rvalid", {31'h0, resp[k].rvalid}, 32'h1);
    check("rdata", resp[k].rdata, exp_rdata);
    check("err", {31'h0, err[k]}, {31'h0, exp_err});
    check("access_cnt", cnt[k], mcnt[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          base_cnt;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req[k]   = '0;
      mcnt[k]  = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_gnt", {31'h0, resp[k].gnt}, 32'h0);
      check("rst_rvalid", {31'h0, resp[k].rvalid}, 32'h0);
      check("rst_rdata", resp[k].rdata, 32'h0);
      check("rst_err", {31'h0, err[k]}, 32'h0);
      check("rst_cnt", cnt[k], 32'h0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    // Write then read, zero wait.
    access(0, 1'b1, 4'hF, BASE + 32'h10, 32'h1234_5678, 0, got);
    access(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 0, got);
    check("wr_rd_value", got, 32'h1234_5678);
    check("wr_rd_cnt", cnt[0], 32'd2);

    // Byte-lane write merge.
    access(0, 1'b1, 4'hF, BASE + 32'h14, 32'hFFFF_FFFF, 0, got);
    access(0, 1'b1, 4'b0101, BASE + 32'h14, 32'hAABB_CCDD, 0, got);
    access(0, 1'b0, 4'hF, BASE + 32'h14, 32'h0, 0, got);
    check("byte_enable", got, 32'hFFBB_FFDD);

    // Preload every word: index for words 0..7, random elsewhere.
    for (int i = 0; i < NW; i++)
      access(0, 1'b1, 4'hF, BASE + 32'(4 * i), (i < 8) ? 32'(i) : $urandom, 0, got);

    // Streaming reads: one grant and one response per cycle.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) req[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: BASE + 32'(4 * i), wdata: 32'h0};
      else       req[0].req = 1'b0;
      #1;
      if (i > 0) begin
        check("stream_rvalid", {31'h0, resp[0].rvalid}, 32'h1);
        check("stream_rdata", resp[0].rdata, 32'(i - 1));
      end
      if (i < 8) begin
        check("stream_gnt", {31'h0, resp[0].gnt}, 32'h1);
        mcnt[0]++;
      end
    end
    check("stream_cnt", cnt[0], mcnt[0]);

    // Out of window: read past the top, write below the base.
    access(0, 1'b0, 4'hF, BASE + 4 * NW, 32'h0, 0, got);
    check("oow_rdata", got, ERR);
    access(0, 1'b1, 4'hF, BASE + 32'(4 * (NW - 1)), 32'hCAFE_F00D, 0, got);
    access(0, 1'b1, 4'hF, BASE - 32'h4, 32'hDEAD_BEEF, 0, got);
    access(0, 1'b0, 4'hF, BASE + 32'(4 * (NW - 1)), 32'h0, 0, got);
    check("oow_write_dropped", got, 32'hCAFE_F00D);

    // Randomized accesses around and inside the window.
    for (int i = 0; i < 40; i++) begin
      a = BASE - 32'h4 + 32'($urandom_range(0, NW + 1) * 4) + 32'($urandom_range(0, 3));
      access(0, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 0, got);
    end

    // Three-cycle wait: full grant, then abandoned request.
    access(1, 1'b1, 4'hF, BASE + 32'h8, 32'h0BAD_F00D, 3, got);
    access(1, 1'b0, 4'hF, BASE + 32'h8, 32'h0, 3, got);
    base_cnt = int'(cnt[1]);
    @(negedge clk);
    req[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: BASE, wdata: 32'h0};
    @(negedge clk);
    req[1].req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("drop_gnt", {31'h0, resp[1].gnt}, 32'h0);
      check("drop_rvalid", {31'h0, resp[1].rvalid}, 32'h0);
      @(negedge clk);
    end
    check("drop_cnt", cnt[1], 32'(base_cnt));

    // Reset while waiting for a grant.
    access(2, 1'b1, 4'hF, BASE + 32'h10, 32'h1234_5678, 5, got);
    @(negedge clk);
    req[2] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: BASE + 32'h10, wdata: 32'h0};
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check("rstwait_gnt", {31'h0, resp[2].gnt}, 32'h0);
    check("rstwait_rvalid", {31'h0, resp[2].rvalid}, 32'h0);
    check("rstwait_err", {31'h0, err[2]}, 32'h0);
    check("rstwait_cnt", cnt[2], 32'h0);
    @(negedge clk);
    req[2].req = 1'b0;
    rst_n[2]   = 1'b1;
    mcnt[2]    = 0;
    access(2, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 5, got);
    check("rstwait_mem_kept", got, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_obi_sram_responder
`default_nettype wire
